// File: rtl/alu_seq_control_pkg.sv
// Shared encodings for the EX-stage ALU control and multicycle sequencer.
package alu_ctrl_pkg;

    // Instruction function field codes
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SRL   = 6'b000010;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;

    // ALU operation codes
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Main-control ALUOp encodings
    typedef enum logic [1:0] {
        ALUOP_ADD     = 2'b00,
        ALUOP_SUB     = 2'b01,
        ALUOP_FUNCT   = 2'b10,
        ALUOP_ADD_ALT = 2'b11
    } alu_op_t;

    // Multicycle sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } seq_state_t;

    // True for funct codes that need the iterative MULTU/DIVU sequencer
    function automatic logic is_multicycle_code(input logic [5:0] code, input logic support_div);
        return (code == F_MULTU) || (support_div && (code == F_DIVU));
    endfunction

endpackage

// File: rtl/alu_seq_control_if.sv
// EX-stage control bundle between the pipeline and the ALU sequencer.
interface alu_seq_control_if;

    logic       valid_in;
    logic [1:0] alu_op;
    logic [5:0] funct;
    logic       flush;

    logic [2:0] alu_operation;
    logic [5:0] unit_sel;
    logic       mul_start;
    logic       div_start;
    logic       busy;
    logic       stall;
    logic       hilo_we;
    logic       done;

    modport master (
        output valid_in, alu_op, funct, flush,
        input  alu_operation, unit_sel, mul_start, div_start,
               busy, stall, hilo_we, done
    );

    modport slave (
        input  valid_in, alu_op, funct, flush,
        output alu_operation, unit_sel, mul_start, div_start,
               busy, stall, hilo_we, done
    );

endinterface

// File: rtl/alu_seq_control_funct_decode.sv
// Combinational ALUOp/funct decoder: ALU operation, legality, multicycle detect
// and the default function-select code.
module alu_funct_decode
    import alu_ctrl_pkg::*;
#(
    parameter bit SUPPORT_DIV = 1'b1
) (
    input  logic       valid_in,
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [2:0] alu_operation,
    output logic       legal,
    output logic       multicycle,
    output logic [5:0] unit_sel_dflt
);

    // ALU operation from ALUOp, with funct refinement for R-type
    always_comb begin
        alu_operation = ALU_ADD;
        case (alu_op)
            ALUOP_SUB: alu_operation = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    F_ADD:   alu_operation = ALU_ADD;
                    F_SUB:   alu_operation = ALU_SUB;
                    F_AND:   alu_operation = ALU_AND;
                    F_OR:    alu_operation = ALU_OR;
                    F_SLT:   alu_operation = ALU_SLT;
                    default: alu_operation = ALU_ADD;
                endcase
            end
            default: alu_operation = ALU_ADD;
        endcase
    end

    // Recognised funct codes; DIVU only when the divider is present
    always_comb begin
        legal = 1'b0;
        case (funct)
            F_AND, F_OR, F_ADD, F_SUB, F_SLT,
            F_SRL, F_MULTU, F_MFHI, F_MFLO: legal = 1'b1;
            F_DIVU:                         legal = SUPPORT_DIV;
            default:                        legal = 1'b0;
        endcase
    end

    assign multicycle    = valid_in && (alu_op == ALUOP_FUNCT) && is_multicycle_code(funct, SUPPORT_DIV);
    assign unit_sel_dflt = legal ? funct : F_ADD;

endmodule

// File: rtl/alu_seq_control.sv
// ALU control plus WIDTH-iteration MULTU/DIVU sequencer with stall,
// flush abort and single-cycle HiLo write strobe.
module alu_seq_control
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter bit          SUPPORT_DIV = 1'b1
) (
    input logic              clk,
    input logic              reset,
    alu_seq_control_if.slave bus
);

    localparam int unsigned       CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    seq_state_t       state, state_next;
    logic [CNT_W-1:0] count, count_next;
    logic [5:0]       code, code_next;

    logic [2:0] alu_operation;
    logic       legal;
    logic       multicycle;
    logic [5:0] unit_sel_dflt;

    logic [5:0] unit_sel;
    logic       busy;
    logic       stall_raw;
    logic       mul_start;
    logic       div_start;
    logic       hilo_we;
    logic       done;

    alu_funct_decode #(
        .SUPPORT_DIV(SUPPORT_DIV)
    ) u_decode (
        .valid_in      (bus.valid_in),
        .alu_op        (bus.alu_op),
        .funct         (bus.funct),
        .alu_operation (alu_operation),
        .legal         (legal),
        .multicycle    (multicycle),
        .unit_sel_dflt (unit_sel_dflt)
    );

    // State, iteration counter and latched multicycle code
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
            code  <= F_ADD;
        end else begin
            state <= state_next;
            count <= count_next;
            code  <= code_next;
        end
    end

    // Next-state and sequencer outputs
    always_comb begin
        state_next = state;
        count_next = count;
        code_next  = code;
        unit_sel   = unit_sel_dflt;
        busy       = 1'b0;
        stall_raw  = 1'b0;
        mul_start  = 1'b0;
        div_start  = 1'b0;
        hilo_we    = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                // Stall in the launch cycle so the op is held in EX; flush kills it
                if (multicycle && !bus.flush) begin
                    state_next = RUN;
                    count_next = '0;
                    code_next  = bus.funct;
                    stall_raw  = 1'b1;
                end
            end
            RUN: begin
                unit_sel  = code;
                busy      = 1'b1;
                stall_raw = 1'b1;
                mul_start = (count == '0) && (code == F_MULTU);
                div_start = (count == '0) && (code == F_DIVU);
                if (bus.flush) begin
                    state_next = IDLE;
                    count_next = '0;
                end else begin
                    count_next = count + CNT_W'(1);
                    if (count == LAST) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                unit_sel   = code;
                hilo_we    = !bus.flush;
                done       = !bus.flush;
                state_next = IDLE;
                count_next = '0;
            end
            default: begin
                state_next = IDLE;
                count_next = '0;
            end
        endcase
    end

    assign bus.alu_operation = alu_operation;
    assign bus.unit_sel      = unit_sel;
    assign bus.mul_start     = mul_start;
    assign bus.div_start     = div_start;
    assign bus.busy          = busy;
    assign bus.stall         = stall_raw && !reset;
    assign bus.hilo_we       = hilo_we;
    assign bus.done          = done;

endmodule

// File: tb/tb_alu_seq_control.sv
// Bench for alu_seq_control: three configurations driven with the same
// stimulus, checked every cycle against an age-based behavioural model,
// plus directed scenarios with hand-computed expectations.
module tb_alu_seq_control;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_r = 1'b1;
    logic       valid_r = 1'b0;
    logic [1:0] alu_op_r = 2'b00;
    logic [5:0] funct_r = 6'd0;
    logic       flush_r = 1'b0;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    localparam int WV  [3] = '{32, 8, 8};
    localparam bit SDV [3] = '{1'b1, 1'b1, 1'b0};

    alu_seq_control_if i0 ();
    alu_seq_control_if i1 ();
    alu_seq_control_if i2 ();

    assign i0.valid_in = valid_r;  assign i0.alu_op = alu_op_r;
    assign i0.funct    = funct_r;  assign i0.flush  = flush_r;
    assign i1.valid_in = valid_r;  assign i1.alu_op = alu_op_r;
    assign i1.funct    = funct_r;  assign i1.flush  = flush_r;
    assign i2.valid_in = valid_r;  assign i2.alu_op = alu_op_r;
    assign i2.funct    = funct_r;  assign i2.flush  = flush_r;

    alu_seq_control #(.WIDTH(32), .SUPPORT_DIV(1'b1)) dut32  (.clk(clk), .reset(reset_r), .bus(i0.slave));
    alu_seq_control #(.WIDTH(8),  .SUPPORT_DIV(1'b1)) dut8   (.clk(clk), .reset(reset_r), .bus(i1.slave));
    alu_seq_control #(.WIDTH(8),  .SUPPORT_DIV(1'b0)) dut8nd (.clk(clk), .reset(reset_r), .bus(i2.slave));

    // Model: age 0 = no op in flight; 1..W = iterating; W+1 = completion cycle
    int         m_age  [3] = '{0, 0, 0};
    logic [5:0] m_code [3] = '{6'd32, 6'd32, 6'd32};

    function automatic logic [2:0] exp_aluop(input logic [1:0] a, input logic [5:0] f);
        if (a == 2'b01) return 3'b110;
        if (a != 2'b10) return 3'b010;
        case (f)
            6'd34:   return 3'b110;
            6'd36:   return 3'b000;
            6'd37:   return 3'b001;
            6'd42:   return 3'b111;
            default: return 3'b010;
        endcase
    endfunction

    function automatic logic legal(input logic [5:0] f, input logic sd);
        case (f)
            6'd36, 6'd37, 6'd32, 6'd34, 6'd42, 6'd2, 6'd25, 6'd16, 6'd18: return 1'b1;
            6'd27:   return sd;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_multi(input int k);
        return valid_r && (alu_op_r == 2'b10) &&
               ((funct_r == 6'd25) || (SDV[k] && funct_r == 6'd27));
    endfunction

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst=%0d t=%0t actual=%0h required=%0h", nm, k, $time, act, exp);
        end
    endtask

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (reset_r) begin
                m_age[k]  <= 0;
                m_code[k] <= 6'd32;
            end else if (m_age[k] == 0) begin
                if (is_multi(k) && !flush_r) begin
                    m_age[k]  <= 1;
                    m_code[k] <= funct_r;
                end
            end else if (m_age[k] == WV[k] + 1 || flush_r) begin
                m_age[k] <= 0;
            end else begin
                m_age[k] <= m_age[k] + 1;
            end
        end
    end

    task automatic cmp(input int k, input logic [2:0] op, input logic [5:0] us, input logic st,
                       input logic bz, input logic ms, input logic ds, input logic hw, input logic dn);
        int         a;
        logic       run_ph;
        logic       done_ph;
        logic [5:0] eus;
        a       = m_age[k];
        run_ph  = (a >= 1) && (a <= WV[k]);
        done_ph = (a == WV[k] + 1);
        eus     = (a == 0) ? (legal(funct_r, SDV[k]) ? funct_r : 6'd32) : m_code[k];
        chk("alu_operation", k, 32'(op), 32'(exp_aluop(alu_op_r, funct_r)));
        chk("unit_sel", k, 32'(us), 32'(eus));
        chk("stall", k, 32'(st), 32'(!reset_r && (run_ph || (a == 0 && is_multi(k) && !flush_r))));
        if (!reset_r) begin
            chk("busy", k, 32'(bz), 32'(run_ph));
            chk("mul_start", k, 32'(ms), 32'(a == 1 && m_code[k] == 6'd25));
            chk("div_start", k, 32'(ds), 32'(a == 1 && m_code[k] == 6'd27));
            chk("hilo_we", k, 32'(hw), 32'(done_ph && !flush_r));
            chk("done", k, 32'(dn), 32'(done_ph && !flush_r));
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            cmp(0, i0.alu_operation, i0.unit_sel, i0.stall, i0.busy, i0.mul_start, i0.div_start, i0.hilo_we, i0.done);
            cmp(1, i1.alu_operation, i1.unit_sel, i1.stall, i1.busy, i1.mul_start, i1.div_start, i1.hilo_we, i1.done);
            cmp(2, i2.alu_operation, i2.unit_sel, i2.stall, i2.busy, i2.mul_start, i2.div_start, i2.hilo_we, i2.done);
        end
    end

    // One cycle: drive just after the edge, return once outputs have settled
    task automatic step(input logic v, input logic [1:0] a, input logic [5:0] f, input logic fl, input logic r);
        @(posedge clk);
        #1;
        valid_r = v; alu_op_r = a; funct_r = f; flush_r = fl; reset_r = r;
        #2;
    endtask

    task automatic do_reset();
        step(1'b0, 2'b00, 6'd0, 1'b0, 1'b1);
        step(1'b0, 2'b00, 6'd0, 1'b0, 1'b1);
    endtask

    localparam logic [5:0] DEC_F  [4] = '{6'd36, 6'd37, 6'd42, 6'd63};
    localparam logic [2:0] DEC_OP [4] = '{3'b000, 3'b001, 3'b111, 3'b010};
    localparam logic [5:0] DEC_US [4] = '{6'b100100, 6'b100101, 6'b101010, 6'b100000};
    localparam logic [5:0] POOL   [12] = '{6'd36, 6'd37, 6'd32, 6'd34, 6'd42, 6'd2,
                                           6'd25, 6'd27, 6'd16, 6'd18, 6'd25, 6'd27};

    initial begin
        int st_cnt, st_first, st_last, ms_cnt, ms_cyc, hw_cnt, hw_cyc, dn_bad, us_bad, n_bad;

        @(posedge clk);
        chk_en = 1'b1;
        do_reset();

        // Reset state with idle inputs
        step(1'b0, 2'b00, 6'd0, 1'b0, 1'b0);
        chk("rst_busy", 0, 32'(i0.busy), 32'd0);
        chk("rst_stall", 0, 32'(i0.stall), 32'd0);
        chk("rst_mul_start", 0, 32'(i0.mul_start), 32'd0);
        chk("rst_hilo_we", 0, 32'(i0.hilo_we), 32'd0);
        chk("rst_unit_sel", 0, 32'(i0.unit_sel), 32'h20);
        chk("rst_alu_operation", 0, 32'(i0.alu_operation), 32'd2);

        // R-type decode table
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 2'b10, DEC_F[i], 1'b0, 1'b0);
            chk("dec_alu_operation", i, 32'(i0.alu_operation), 32'(DEC_OP[i]));
            chk("dec_unit_sel", i, 32'(i0.unit_sel), 32'(DEC_US[i]));
            chk("dec_stall", i, 32'(i0.stall), 32'd0);
        end

        // MULTU at cycle 0 held in EX through cycle 33, MFHI at 34
        do_reset();
        st_cnt = 0; st_first = -1; st_last = -1; ms_cnt = 0; ms_cyc = -1;
        hw_cnt = 0; hw_cyc = -1; dn_bad = 0; us_bad = 0;
        for (int c = 0; c < 34; c++) begin
            step(1'b1, 2'b10, 6'd25, 1'b0, 1'b0);
            if (i0.stall) begin st_cnt++; if (st_first < 0) st_first = c; st_last = c; end
            if (i0.mul_start) begin ms_cnt++; ms_cyc = c; end
            if (i0.hilo_we) begin hw_cnt++; hw_cyc = c; end
            if (i0.done !== i0.hilo_we) dn_bad++;
            if (i0.unit_sel !== 6'b011001) us_bad++;
        end
        step(1'b1, 2'b10, 6'd16, 1'b0, 1'b0);
        chk("mfhi_unit_sel", 0, 32'(i0.unit_sel), 32'h10);
        chk("mfhi_stall", 0, 32'(i0.stall), 32'd0);
        chk("mul_stall_cycles", 0, 32'(st_cnt), 32'd33);
        chk("mul_stall_first", 0, 32'(st_first), 32'd0);
        chk("mul_stall_last", 0, 32'(st_last), 32'd32);
        chk("mul_start_count", 0, 32'(ms_cnt), 32'd1);
        chk("mul_start_cycle", 0, 32'(ms_cyc), 32'd1);
        chk("mul_hilo_count", 0, 32'(hw_cnt), 32'd1);
        chk("mul_hilo_cycle", 0, 32'(hw_cyc), 32'd33);
        chk("mul_done_vs_hilo", 0, 32'(dn_bad), 32'd0);
        chk("mul_unit_sel_held", 0, 32'(us_bad), 32'd0);

        // DIVU on WIDTH=8 with and without divider support
        do_reset();
        ms_cnt = 0; ms_cyc = -1; hw_cnt = 0; hw_cyc = -1; n_bad = 0;
        for (int c = 0; c < 10; c++) begin
            step(1'b1, 2'b10, 6'd27, 1'b0, 1'b0);
            if (i1.div_start) begin ms_cnt++; ms_cyc = c; end
            if (i1.hilo_we) begin hw_cnt++; hw_cyc = c; end
            if (i2.stall || i2.div_start || i2.busy || i2.unit_sel !== 6'b100000) n_bad++;
        end
        chk("div_start_count", 1, 32'(ms_cnt), 32'd1);
        chk("div_start_cycle", 1, 32'(ms_cyc), 32'd1);
        chk("div_hilo_count", 1, 32'(hw_cnt), 32'd1);
        chk("div_hilo_cycle", 1, 32'(hw_cyc), 32'd9);
        chk("nodiv_inert_cycles", 2, 32'(n_bad), 32'd0);

        // MULTU flushed at cycle 10, new MULTU at 12 completing at 45
        do_reset();
        hw_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            step(1'b1, 2'b10, 6'd25, 1'b0, 1'b0);
            if (i0.hilo_we) hw_cnt++;
        end
        step(1'b1, 2'b10, 6'd25, 1'b1, 1'b0);
        if (i0.hilo_we) hw_cnt++;
        step(1'b0, 2'b00, 6'd0, 1'b0, 1'b0);
        chk("flush_idle_busy", 0, 32'(i0.busy), 32'd0);
        chk("flush_idle_stall", 0, 32'(i0.stall), 32'd0);
        chk("flush_no_hilo", 0, 32'(hw_cnt), 32'd0);
        step(1'b1, 2'b10, 6'd25, 1'b0, 1'b0);
        chk("relaunch_stall", 0, 32'(i0.stall), 32'd1);
        chk("relaunch_busy", 0, 32'(i0.busy), 32'd0);
        step(1'b1, 2'b10, 6'd25, 1'b0, 1'b0);
        chk("relaunch_mul_start", 0, 32'(i0.mul_start), 32'd1);
        hw_cnt = 0;
        for (int c = 14; c < 45; c++) begin
            step(1'b1, 2'b10, 6'd25, 1'b0, 1'b0);
            if (i0.hilo_we) hw_cnt++;
        end
        chk("relaunch_early_hilo", 0, 32'(hw_cnt), 32'd0);
        step(1'b1, 2'b10, 6'd25, 1'b0, 1'b0);
        chk("relaunch_hilo_cycle45", 0, 32'(i0.hilo_we), 32'd1);

        // Reset at cycle 5 of a MULTU, new MULTU at 7 completing at 40
        do_reset();
        for (int c = 0; c < 5; c++) step(1'b1, 2'b10, 6'd25, 1'b0, 1'b0);
        step(1'b1, 2'b10, 6'd25, 1'b0, 1'b1);
        chk("reset_forces_stall0", 0, 32'(i0.stall), 32'd0);
        step(1'b0, 2'b00, 6'd0, 1'b0, 1'b0);
        chk("post_reset_busy", 0, 32'(i0.busy), 32'd0);
        chk("post_reset_outs", 0, 32'({i0.stall, i0.mul_start, i0.div_start, i0.hilo_we, i0.done}), 32'd0);
        hw_cnt = 0; ms_cyc = -1;
        for (int c = 7; c < 40; c++) begin
            step(1'b1, 2'b10, 6'd25, 1'b0, 1'b0);
            if (i0.hilo_we) hw_cnt++;
            if (i0.mul_start) ms_cyc = c;
        end
        chk("post_reset_start_cycle", 0, 32'(ms_cyc), 32'd8);
        chk("post_reset_early_hilo", 0, 32'(hw_cnt), 32'd0);
        step(1'b1, 2'b10, 6'd25, 1'b0, 1'b0);
        chk("post_reset_hilo_cycle40", 0, 32'(i0.hilo_we), 32'd1);

        // Flush beats a multicycle op in the same idle cycle
        do_reset();
        step(1'b1, 2'b10, 6'd25, 1'b1, 1'b0);
        chk("flush_launch_stall", 0, 32'(i0.stall), 32'd0);
        step(1'b0, 2'b00, 6'd0, 1'b0, 1'b0);
        chk("flush_launch_busy", 0, 32'(i0.busy), 32'd0);

        // Randomised traffic, checked by the model every cycle
        for (int c = 0; c < 4000; c++) begin
            logic [5:0] f;
            logic [1:0] a;
            f = ($urandom_range(0, 3) == 0) ? 6'($urandom()) : POOL[$urandom_range(0, 11)];
            a = ($urandom_range(0, 1) == 0) ? 2'b10 : 2'($urandom());
            step(1'($urandom_range(0, 3) != 0), a, f,
                 1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 99) == 0));
        end

        step(1'b0, 2'b00, 6'd0, 1'b0, 1'b0);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
